// File: rtl/pmem_burst_responder_pkg.sv
// Shared types and sizing for the physical-memory line responder.
// A 256-bit line is moved as a burst of 64-bit beats.
package pmem_burst_responder_pkg;
   localparam int ADDR_W      = 32;
   localparam int BEAT_W      = 64;
   localparam int BEATS       = 4;
   localparam int LINE_W      = BEAT_W * BEATS;
   localparam int OFFSET_BITS = 5;
   localparam int CNT_W       = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} pmem_resp_state_t;

   // Line base address: the in-line byte offset is forced to zero.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'((1 << OFFSET_BITS) - 1);
   endfunction
endpackage

// File: rtl/pmem_burst_responder_if.sv
// L2-side line port (pmem_*) and off-chip burst port (bmem_*) bundled together.
// slave = responder view, master = L2 + burst memory view.
interface pmem_burst_responder_if;
   import pmem_burst_responder_pkg::*;

   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_read;
   logic              pmem_write;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;
   logic [ADDR_W-1:0] bmem_address;
   logic              bmem_read;
   logic              bmem_write;
   logic [BEAT_W-1:0] bmem_wdata;
   logic [BEAT_W-1:0] bmem_rdata;
   logic              bmem_resp;

   modport slave (
      input  pmem_address, pmem_wdata, pmem_read, pmem_write, bmem_rdata, bmem_resp,
      output pmem_resp, pmem_rdata, bmem_address, bmem_read, bmem_write, bmem_wdata
   );

   modport master (
      output pmem_address, pmem_wdata, pmem_read, pmem_write, bmem_rdata, bmem_resp,
      input  pmem_resp, pmem_rdata, bmem_address, bmem_read, bmem_write, bmem_wdata
   );
endinterface

// File: rtl/pmem_burst_responder_burst_line_buffer.sv
// One-line staging register: whole-line load for writes, per-beat insert for
// read capture, per-beat extract feeding the write beat.
module burst_line_buffer #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_i,
   input  logic [BEATS*BEAT_W-1:0]    line_i,
   input  logic                       ins_i,
   input  logic [$clog2(BEATS)-1:0]   idx_i,
   input  logic [BEAT_W-1:0]          beat_i,
   output logic [BEATS*BEAT_W-1:0]    next_o,
   output logic [BEAT_W-1:0]          beat_o
);
   logic [BEATS-1:0][BEAT_W-1:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      if (load_i)     line_d = line_i;
      else if (ins_i) line_d[idx_i] = beat_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line_q <= '0;
      else        line_q <= line_d;
   end

   // next_o lets the caller snapshot a line the same cycle its last beat lands.
   assign next_o = line_d;
   assign beat_o = line_q[idx_i];
endmodule

// File: rtl/pmem_burst_responder.sv
// Serves each 256-bit pmem line request as a 4-beat burst on bmem and pulses
// pmem_resp once per line. Holds the FSM, beat counter and address latch.
module pmem_burst_responder
   import pmem_burst_responder_pkg::*;
(
   input logic                     clk,
   input logic                     rst_n,
   pmem_burst_responder_if.slave   bus_if
);
   pmem_resp_state_t  state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [LINE_W-1:0] rdata_q;
   logic              load, ins, cap;
   logic [LINE_W-1:0] buf_next;
   logic [BEAT_W-1:0] buf_beat;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      load    = 1'b0;
      ins     = 1'b0;
      cap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Write has priority when both requests are up.
            if (bus_if.pmem_write) begin
               addr_d  = line_base(bus_if.pmem_address);
               load    = 1'b1;
               wr_d    = 1'b1;
               state_d = WR_BURST;
            end else if (bus_if.pmem_read) begin
               addr_d  = line_base(bus_if.pmem_address);
               rd_d    = 1'b1;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (bus_if.bmem_resp) begin
               ins   = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  cap     = 1'b1;
                  rd_d    = 1'b0;
                  state_d = RESP;
               end
            end
         end
         WR_BURST: begin
            if (bus_if.bmem_resp) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BEATS - 1)) begin
                  wr_d    = 1'b0;
                  state_d = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         if (cap) rdata_q <= buf_next;
      end
   end

   burst_line_buffer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_line_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .line_i (bus_if.pmem_wdata),
      .ins_i  (ins),
      .idx_i  (cnt_q),
      .beat_i (bus_if.bmem_rdata),
      .next_o (buf_next),
      .beat_o (buf_beat)
   );

   assign bus_if.pmem_resp    = (state_q == RESP);
   assign bus_if.pmem_rdata   = rdata_q;
   assign bus_if.bmem_address = addr_q;
   assign bus_if.bmem_read    = rd_q;
   assign bus_if.bmem_write   = wr_q;
   assign bus_if.bmem_wdata   = buf_beat;
endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder: burst memory is emulated beat by beat
// with chosen stall gaps; each scenario task checks its own hand-computed results.
module tb_pmem_burst_responder;
   import pmem_burst_responder_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pmem_burst_responder_if bus();

   pmem_burst_responder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   int total = 0;
   int bad   = 0;

   localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] W1 = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                                  64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
   localparam logic [255:0] W2 = {64'hAAAA_0000_BBBB_0003, 64'hAAAA_0000_BBBB_0002,
                                  64'hAAAA_0000_BBBB_0001, 64'hAAAA_0000_BBBB_0000};
   localparam logic [255:0] L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
   localparam logic [255:0] L4 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                  64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
   localparam logic [255:0] L5 = {64'hBEEF_5555_0000_0004, 64'hBEEF_5555_0000_0003,
                                  64'hBEEF_5555_0000_0002, 64'hBEEF_5555_0000_0001};

   // Observations recorded by serve() for the scenario tasks to judge.
   logic [3:0][63:0] s_wseen;
   logic [255:0]     s_rdata;
   logic [31:0]      s_addr;
   bit               s_addr_ok, s_held_ok, s_strobe_ok, s_strobe_at_resp;
   int               s_resp_cyc;

   // Emulates burst memory for one transaction whose request was set at the
   // previous negedge. Cycle 1 is the first cycle after the request is sampled.
   // Returns at the negedge where pmem_resp is seen, with requests dropped.
   task automatic serve(input bit wr, input logic [255:0] rd_line,
                        input int g0, input int g1, input int g2, input int g3,
                        input bit chg);
      int gaps[4];
      int k, g;
      logic [63:0] wfirst;
      bit have;
      gaps = '{g0, g1, g2, g3};
      k = 0; g = 0; have = 0; wfirst = '0;
      s_resp_cyc = -1; s_addr_ok = 1; s_held_ok = 1; s_strobe_ok = 1;
      s_strobe_at_resp = 0; s_wseen = '0; s_rdata = '0; s_addr = '0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (bus.pmem_resp) begin
            s_resp_cyc       = cyc;
            s_rdata          = bus.pmem_rdata;
            s_strobe_at_resp = bus.bmem_read | bus.bmem_write;
            bus.pmem_read  = 1'b0;
            bus.pmem_write = 1'b0;
            bus.bmem_resp  = 1'b0;
            return;
         end
         if (cyc == 1) s_addr = bus.bmem_address;
         else if (bus.bmem_address !== s_addr) s_addr_ok = 0;
         if (cyc == 2 && chg) begin
            bus.pmem_address = ~bus.pmem_address;
            bus.pmem_wdata   = ~bus.pmem_wdata;
         end
         if (k < 4) begin
            if (wr ? (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0)
                   : (bus.bmem_read !== 1'b1 || bus.bmem_write !== 1'b0)) s_strobe_ok = 0;
            if (!have) begin wfirst = bus.bmem_wdata; have = 1; end
            else if (bus.bmem_wdata !== wfirst) s_held_ok = 0;
            if (g < gaps[k]) begin
               bus.bmem_resp  = 1'b0;
               bus.bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
               g++;
            end else begin
               bus.bmem_resp  = 1'b1;
               bus.bmem_rdata = rd_line[64*k +: 64];
               s_wseen[k]     = bus.bmem_wdata;
               k++; g = 0; have = 0;
            end
         end else begin
            bus.bmem_resp = 1'b0;
         end
      end
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      bus.bmem_resp  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++; if (bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL reset_pmem_resp got=%b exp=0", bus.pmem_resp); end
      total++; if (bus.pmem_rdata !== '0) begin bad++; $display("FAIL reset_pmem_rdata got=%h exp=0", bus.pmem_rdata); end
      total++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", bus.bmem_read, bus.bmem_write); end
      total++; if (bus.bmem_address !== '0) begin bad++; $display("FAIL reset_bmem_address got=%h exp=0", bus.bmem_address); end
      total++; if (bus.bmem_wdata !== '0) begin bad++; $display("FAIL reset_bmem_wdata got=%h exp=0", bus.bmem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read_zero_wait();
      @(negedge clk);
      bus.pmem_address = 32'h0000_1234;
      bus.pmem_read    = 1'b1;
      serve(1'b0, L1, 0, 0, 0, 0, 1'b0);
      total++; if (s_resp_cyc != 5) begin bad++; $display("FAIL rd0_resp_cycle got=%0d exp=5", s_resp_cyc); end
      total++; if (s_addr !== 32'h0000_1220 || !s_addr_ok) begin bad++; $display("FAIL rd0_address got=%h stable=%0d exp=00001220", s_addr, s_addr_ok); end
      total++; if (!s_strobe_ok || s_strobe_at_resp) begin bad++; $display("FAIL rd0_strobes burst_ok=%0d at_resp=%0d exp=1/0", s_strobe_ok, s_strobe_at_resp); end
      total++; if (s_rdata !== L1) begin bad++; $display("FAIL rd0_rdata got=%h exp=%h", s_rdata, L1); end
      @(negedge clk);
      total++; if (bus.pmem_resp !== 1'b0 || bus.pmem_rdata !== L1) begin bad++; $display("FAIL rd0_after_resp resp=%b rdata=%h exp=0/%h", bus.pmem_resp, bus.pmem_rdata, L1); end
   endtask

   task automatic test_write_stalls();
      @(negedge clk);
      bus.pmem_address = 32'h0000_805F;
      bus.pmem_wdata   = W1;
      bus.pmem_write   = 1'b1;
      serve(1'b1, '0, 0, 3, 1, 5, 1'b0);
      // accepts at cycles 1,5,7,13 -> RESP in cycle 14
      total++; if (s_resp_cyc != 14) begin bad++; $display("FAIL wr_resp_cycle got=%0d exp=14", s_resp_cyc); end
      total++; if (s_wseen !== W1) begin bad++; $display("FAIL wr_beats got=%h exp=%h", s_wseen, W1); end
      total++; if (!s_held_ok) begin bad++; $display("FAIL wr_beat_hold got=changed exp=held"); end
      total++; if (!s_strobe_ok || s_strobe_at_resp) begin bad++; $display("FAIL wr_strobes burst_ok=%0d at_resp=%0d exp=1/0", s_strobe_ok, s_strobe_at_resp); end
      total++; if (s_addr !== 32'h0000_8040) begin bad++; $display("FAIL wr_address got=%h exp=00008040", s_addr); end
      total++; if (s_rdata !== L1) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=%h", s_rdata, L1); end
      @(negedge clk);
      total++; if (bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL wr_single_resp got=%b exp=0", bus.pmem_resp); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      bus.pmem_address = 32'h0000_0100;
      bus.pmem_wdata   = W2;
      bus.pmem_read    = 1'b1;
      bus.pmem_write   = 1'b1;
      serve(1'b1, L3, 0, 0, 0, 0, 1'b0);
      total++; if (!s_strobe_ok || s_resp_cyc != 5) begin bad++; $display("FAIL both_write_only burst_ok=%0d resp_cyc=%0d exp=1/5", s_strobe_ok, s_resp_cyc); end
      total++; if (s_wseen !== W2) begin bad++; $display("FAIL both_beats got=%h exp=%h", s_wseen, W2); end
      total++; if (s_rdata !== L1) begin bad++; $display("FAIL both_rdata_kept got=%h exp=%h", s_rdata, L1); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      bus.pmem_address = 32'h0000_2000;
      bus.pmem_read    = 1'b1;
      @(negedge clk); bus.bmem_resp = 1'b1; bus.bmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk); bus.bmem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
      @(negedge clk); bus.bmem_rdata = 64'hCCCC_CCCC_CCCC_CCCC;
      #1 rst_n = 1'b0; bus.pmem_read = 1'b0; bus.bmem_resp = 1'b0;
      #1;
      total++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0 || bus.pmem_resp !== 1'b0)
         begin bad++; $display("FAIL midrst_strobes got=%b%b%b exp=000", bus.bmem_read, bus.bmem_write, bus.pmem_resp); end
      total++; if (bus.bmem_address !== '0 || bus.bmem_wdata !== '0 || bus.pmem_rdata !== '0)
         begin bad++; $display("FAIL midrst_buses addr=%h wdata=%h rdata=%h exp=0", bus.bmem_address, bus.bmem_wdata, bus.pmem_rdata); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.bmem_read !== 1'b0 || bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL midrst_idle rd=%b resp=%b exp=0/0", bus.bmem_read, bus.pmem_resp); end
      bus.pmem_address = 32'h0000_3008;
      bus.pmem_read    = 1'b1;
      serve(1'b0, L3, 1, 0, 2, 0, 1'b0);
      total++; if (s_resp_cyc != 8 || s_rdata !== L3) begin bad++; $display("FAIL midrst_new_read cyc=%0d rdata=%h exp=8/%h", s_resp_cyc, s_rdata, L3); end
      total++; if (s_addr !== 32'h0000_3000) begin bad++; $display("FAIL midrst_address got=%h exp=00003000", s_addr); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.pmem_address = 32'h0000_4000;
      bus.pmem_wdata   = W1;
      bus.pmem_write   = 1'b1;
      serve(1'b1, '0, 0, 0, 0, 0, 1'b0);
      total++; if (s_resp_cyc != 5 || s_wseen !== W1) begin bad++; $display("FAIL b2b_write cyc=%0d beats=%h exp=5/%h", s_resp_cyc, s_wseen, W1); end
      // read request raised in the cycle after pmem_resp
      bus.pmem_address = 32'h0000_5010;
      bus.pmem_read    = 1'b1;
      @(negedge clk);
      total++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0 || bus.pmem_resp !== 1'b0)
         begin bad++; $display("FAIL b2b_idle_gap got=%b%b%b exp=000", bus.bmem_read, bus.bmem_write, bus.pmem_resp); end
      serve(1'b0, L4, 0, 0, 0, 0, 1'b0);
      total++; if (!s_strobe_ok || s_resp_cyc != 5) begin bad++; $display("FAIL b2b_read_timing burst_ok=%0d cyc=%0d exp=1/5", s_strobe_ok, s_resp_cyc); end
      total++; if (s_rdata !== L4 || s_addr !== 32'h0000_5000) begin bad++; $display("FAIL b2b_read_data rdata=%h addr=%h exp=%h/00005000", s_rdata, s_addr, L4); end
      @(negedge clk);
   endtask

   task automatic test_spurious_and_latch();
      bit quiet = 1;
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = 64'hFFFF_0000_FFFF_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0 || bus.pmem_resp !== 1'b0) quiet = 0;
      end
      bus.bmem_resp = 1'b0;
      total++; if (!quiet) begin bad++; $display("FAIL spurious_idle got=active exp=quiet"); end
      bus.pmem_address = 32'h0000_6004;
      bus.pmem_read    = 1'b1;
      serve(1'b0, L5, 0, 2, 0, 1, 1'b1);
      total++; if (s_addr !== 32'h0000_6000 || !s_addr_ok) begin bad++; $display("FAIL latch_rd_address got=%h stable=%0d exp=00006000", s_addr, s_addr_ok); end
      total++; if (s_rdata !== L5 || s_resp_cyc != 8) begin bad++; $display("FAIL latch_rd_data rdata=%h cyc=%0d exp=%h/8", s_rdata, s_resp_cyc, L5); end
      @(negedge clk);
      bus.pmem_address = 32'h0000_7000;
      bus.pmem_wdata   = W2;
      bus.pmem_write   = 1'b1;
      serve(1'b1, '0, 1, 1, 1, 1, 1'b1);
      total++; if (s_wseen !== W2 || s_addr !== 32'h0000_7000 || !s_addr_ok)
         begin bad++; $display("FAIL latch_wr beats=%h addr=%h exp=%h/00007000", s_wseen, s_addr, W2); end
      total++; if (s_rdata !== L5) begin bad++; $display("FAIL latch_wr_rdata_kept got=%h exp=%h", s_rdata, L5); end
      @(negedge clk);
   endtask

   initial begin
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.bmem_rdata   = '0;
      bus.bmem_resp    = 1'b0;
      test_reset();
      test_read_zero_wait();
      test_write_stalls();
      test_simultaneous();
      test_reset_mid_burst();
      test_back_to_back();
      test_spurious_and_latch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
